piso_serializer: RTL

Parallel-in serial-out shift register with a bit counter, a two-state FSM and a valid/ready load handshake. Accepts a WIDTH-bit word and emits it one bit per enabled clock on a single serial line, with framing strobes. It is the transmit-side counterpart of the 8-bit SIPO capture register. Frames are MSB-first by default, so the first bit sent lands in the SIPO's Q[7] after 8 shifts.

---
 rtl/piso_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in serial-out shift register. A WIDTH-bit word is accepted through
// a valid/ready handshake and sent out one bit per enabled clock on "so".
// Framing strobes mark the first and last bit of every frame. A new word may
// be accepted while the last bit of the current frame is on the line, which
// gives gapless back-to-back frames.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1 = din[WIDTH-1] goes out first, 0 = din[0] goes out first
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   din          parallel word to serialize
//   load_valid   din is valid, request to load
//   load_ready   a word can be accepted this cycle
//   shift_en     bit-rate enable; the frame advances only when high
//   so           serial data out
//   so_valid     so carries a frame bit this cycle
//   frame_start  first bit of a frame is on so
//   frame_done   last bit of a frame is on so
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           last_bit;
    logic           accept;

    // State, shift register and bit counter. Reset abandons any frame in
    // progress; since frame_done is derived from the state it never fires
    // for an abandoned frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            sreg  <= sreg_next;
            count <= count_next;
        end
    end

    // Output decode and next-state logic. The output bit always sits at the
    // end of sreg facing the line, so a shift moves the next bit into place
    // and zero-fills the opposite end. load_ready opens only in IDLE or on
    // the last bit of a frame when that bit is about to leave the line, so a
    // reload never overwrites a bit that has not been sent.
    always_comb begin
        state_next   = state;
        sreg_next    = sreg;
        count_next   = count;

        last_bit     = (state == SHIFT) && (count == LAST);
        sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

        load_ready   = reset && ((state == IDLE) || (last_bit && shift_en));
        accept       = load_valid && load_ready;

        so_valid     = (state == SHIFT);
        so           = so_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
        frame_start  = reset && (state == SHIFT) && (count == '0);
        frame_done   = reset && last_bit;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    sreg_next  = din;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (accept) begin
                    sreg_next  = din;
                    count_next = '0;
                end else if (shift_en) begin
                    sreg_next = sreg_shifted;
                    if (last_bit) begin
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sreg_next  = '0;
                count_next = '0;
            end
        endcase
    end

endmodule
